// File: rtl/slfifo_ts_rx_pkg.sv
// Shared constants and FSM encodings for the slave-FIFO TS receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package slfifo_pkg;

  localparam int         PKT_LEN_DEF   = 188;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'h47;
  localparam logic [1:0] FIFO_ADR_DEF  = 2'b10;
  localparam int         RD_GAP_DEF    = 8;

  localparam int ST_W = 3;

  // One-hot so each state is a single flop test.
  typedef enum logic [ST_W-1:0] {
    ST_HUNT   = 3'b001,
    ST_VERIFY = 3'b010,
    ST_LOCK   = 3'b100
  } state_t;

endpackage

// File: rtl/slfifo_ts_rx_if.sv
// Slave-FIFO pins plus TS byte-stream output and status of the receive path.
// Latency: n/a (wires only).
// Backpressure: ts_afull flows from downstream back into the read scheduler.
// Ports: master = receiver side (drives sl_rd/sl_oe/sl_fifo_adr and ts_*),
//        slave  = environment side (drives sl_data/sl_ef/ts_afull).
interface slfifo_ts_rx_if;
  logic [7:0]  sl_data;
  logic        sl_ef;
  logic        sl_rd;
  logic        sl_oe;
  logic [1:0]  sl_fifo_adr;
  logic        ts_afull;
  logic        ts_valid;
  logic [7:0]  ts_data;
  logic        ts_sop;
  logic        ts_eop;
  logic        ts_lock;
  logic [15:0] pkt_cnt;
  logic [7:0]  sync_err_cnt;

  modport master (
    input  sl_data, sl_ef, ts_afull,
    output sl_rd, sl_oe, sl_fifo_adr,
    output ts_valid, ts_data, ts_sop, ts_eop, ts_lock, pkt_cnt, sync_err_cnt
  );

  modport slave (
    output sl_data, sl_ef, ts_afull,
    input  sl_rd, sl_oe, sl_fifo_adr,
    input  ts_valid, ts_data, ts_sop, ts_eop, ts_lock, pkt_cnt, sync_err_cnt
  );
endinterface

// File: rtl/slfifo_ts_rx_rd_ctrl.sv
// Slave-FIFO read scheduler: one read slot every RD_GAP cycles, captures the byte.
// Latency: byte_r/byte_vld valid the cycle after the read decision edge.
// Backpressure: a slot is skipped when the synced empty flag or ts_afull forbids it.
// Ports: clk/rst; sl_data/sl_ef from pins; ts_afull from downstream;
//        sl_rd/sl_oe to pins; byte_r/byte_vld to the sync FSM.
module slfifo_rd_ctrl #(
  parameter int RD_GAP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sl_data,
  input  logic       sl_ef,
  input  logic       ts_afull,
  output logic       sl_rd,
  output logic       sl_oe,
  output logic [7:0] byte_r,
  output logic       byte_vld
);
  localparam logic [7:0] GAP_LAST = 8'(RD_GAP - 1);

  logic       ef_s1;
  logic       ef_s2;
  logic [7:0] gap;
  logic       fire;

  // RD_GAP >= 4 covers the two sync flops plus the controller's flag update,
  // so ef_s2 already reflects the previous read by the next slot.
  assign fire = (gap == GAP_LAST) && ef_s2 && !ts_afull;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ef_s1    <= 1'b0;
      ef_s2    <= 1'b0;
      gap      <= 8'd0;
      sl_rd    <= 1'b1;
      sl_oe    <= 1'b1;
      byte_r   <= 8'd0;
      byte_vld <= 1'b0;
    end else begin
      ef_s1    <= sl_ef;
      ef_s2    <= ef_s1;
      gap      <= (gap == GAP_LAST) ? 8'd0 : gap + 8'd1;
      sl_oe    <= 1'b0;
      sl_rd    <= !fire;
      byte_vld <= fire;
      if (fire) byte_r <= sl_data;
    end
  end
endmodule

// File: rtl/slfifo_ts_rx.sv
// Slave-FIFO OUT-endpoint receiver: recovers 188-byte TS alignment on 0x47.
// Latency: output byte registered one cycle after the sl_rd falling edge.
// Backpressure: ts_afull (sampled at read slots) holds off further reads.
// Ports: clk/rst plain; bus (master modport) carries slave-FIFO pins,
//        TS byte stream with sop/eop, lock flag and statistics counters.
module slfifo_ts_rx
  import slfifo_pkg::*;
#(
  parameter int         PKT_LEN   = PKT_LEN_DEF,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter logic [1:0] FIFO_ADR  = FIFO_ADR_DEF,
  parameter int         RD_GAP    = RD_GAP_DEF
) (
  input  logic           clk,
  input  logic           rst,
  slfifo_ts_rx_if.master bus
);
  localparam int               CNT_W    = $clog2(PKT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PKT_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_LEN - 1);

  logic [7:0]       byte_r;
  logic             byte_vld;
  logic             is_sync;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             vld_r, vld_n;
  logic             sop_r, sop_n;
  logic             eop_r, eop_n;
  logic [7:0]       data_r, data_n;
  logic [15:0]      pkt_r, pkt_n;
  logic [7:0]       err_r, err_n;

  slfifo_rd_ctrl #(.RD_GAP(RD_GAP)) u_rd_ctrl (
    .clk      (clk),
    .rst      (rst),
    .sl_data  (bus.sl_data),
    .sl_ef    (bus.sl_ef),
    .ts_afull (bus.ts_afull),
    .sl_rd    (bus.sl_rd),
    .sl_oe    (bus.sl_oe),
    .byte_r   (byte_r),
    .byte_vld (byte_vld)
  );

  assign is_sync = (byte_r == SYNC_BYTE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_HUNT;
      cnt    <= '0;
      vld_r  <= 1'b0;
      sop_r  <= 1'b0;
      eop_r  <= 1'b0;
      data_r <= 8'd0;
      pkt_r  <= 16'd0;
      err_r  <= 8'd0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      vld_r  <= vld_n;
      sop_r  <= sop_n;
      eop_r  <= eop_n;
      data_r <= data_n;
      pkt_r  <= pkt_n;
      err_r  <= err_n;
    end
  end

  // VERIFY counts up to PKT_LEN so the byte landing on cnt==PKT_LEN is the
  // candidate next sync; LOCK counts 0..PKT_LEN-1 so cnt==0 is a packet start.
  // Lock loss is only judged at cnt==0, so a started packet always completes.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    vld_n   = 1'b0;
    sop_n   = 1'b0;
    eop_n   = 1'b0;
    data_n  = data_r;
    pkt_n   = pkt_r;
    err_n   = err_r;
    if (byte_vld) begin
      unique case (state)
        ST_HUNT: begin
          if (is_sync) begin
            state_n = ST_VERIFY;
            cnt_n   = CNT_W'(1);
          end
        end
        ST_VERIFY: begin
          if (cnt == CNT_FULL) begin
            if (is_sync) begin
              state_n = ST_LOCK;
              vld_n   = 1'b1;
              sop_n   = 1'b1;
              data_n  = byte_r;
              cnt_n   = CNT_W'(1);
            end else begin
              state_n = ST_HUNT;
              cnt_n   = '0;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_LOCK: begin
          if (cnt == '0 && !is_sync) begin
            state_n = ST_HUNT;
            if (err_r != 8'hFF) err_n = err_r + 8'd1;
          end else begin
            vld_n  = 1'b1;
            data_n = byte_r;
            sop_n  = (cnt == '0);
            if (cnt == CNT_LAST) begin
              eop_n = 1'b1;
              pkt_n = pkt_r + 16'd1;
              cnt_n = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        default: begin
          state_n = ST_HUNT;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign bus.sl_fifo_adr  = FIFO_ADR;
  assign bus.ts_valid     = vld_r;
  assign bus.ts_data      = data_r;
  assign bus.ts_sop       = sop_r;
  assign bus.ts_eop       = eop_r;
  assign bus.ts_lock      = (state == ST_LOCK);
  assign bus.pkt_cnt      = pkt_r;
  assign bus.sync_err_cnt = err_r;
endmodule

// File: tb/tb_slfifo_ts_rx.sv
// Bench for slfifo_ts_rx: slave-FIFO source model feeding TS packets,
// scoreboard of expected output bytes popped as the DUT emits them.
module tb_slfifo_ts_rx;
  localparam int PKT_LEN = 188;
  localparam int RD_GAP  = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } exp_t;

  logic clk;
  logic rst;

  slfifo_ts_rx_if bus();

  slfifo_ts_rx #(.RD_GAP(RD_GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] src_q[$];
  exp_t       exp_q[$];
  bit         ef_hold = 1'b0;
  int         pop_cnt = 0;
  int         n_out = 0, n_sop = 0, n_eop = 0;
  logic       prev_valid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave-FIFO source: a byte leaves the endpoint while SLRD is low.
  always @(negedge clk) begin
    if (bus.sl_rd === 1'b0 && src_q.size() > 0) begin
      void'(src_q.pop_front());
      pop_cnt++;
    end
    bus.sl_data = (src_q.size() > 0) ? src_q[0] : 8'h00;
    bus.sl_ef   = (src_q.size() > 0) && !ef_hold;
  end

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.ts_valid === 1'b1) begin
      exp_t e;
      n_out++;
      if (bus.ts_sop) n_sop++;
      if (bus.ts_eop) n_eop++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_byte got data=%02h sop=%b eop=%b required no output",
                 bus.ts_data, bus.ts_sop, bus.ts_eop);
      end else begin
        e = exp_q.pop_front();
        if ({bus.ts_data, bus.ts_sop, bus.ts_eop} !== {e.data, e.sop, e.eop}) begin
          failures++;
          $display("FAIL out_byte got data=%02h sop=%b eop=%b required data=%02h sop=%b eop=%b",
                   bus.ts_data, bus.ts_sop, bus.ts_eop, e.data, e.sop, e.eop);
        end
      end
      checks++;
      if (bus.ts_lock !== 1'b1) begin
        failures++;
        $display("FAIL lock_on_valid got %b required 1", bus.ts_lock);
      end
      checks++;
      if (prev_valid === 1'b1) begin
        failures++;
        $display("FAIL valid_pulse got back-to-back valid required single-cycle pulse");
      end
    end
    prev_valid = bus.ts_valid;
  end

  task automatic push_pkt(input logic [7:0] first, input bit emit);
    logic [7:0] b;
    for (int i = 0; i < PKT_LEN; i++) begin
      // Payload 0x80.. wraps to 0x3A and never contains 0x47.
      b = (i == 0) ? first : 8'(8'h80 + i - 1);
      src_q.push_back(b);
      if (emit) exp_q.push_back(exp_t'{data: b, sop: 1'(i == 0), eop: 1'(i == PKT_LEN - 1)});
    end
  endtask

  task automatic apply_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    bus.ts_afull = 1'b0;
    ef_hold = 1'b0;
    src_q.delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_pop(input int target, input string tag);
    int n = 0;
    while (pop_cnt < target && n < 20000) begin @(negedge clk); n++; end
    #1;
    if (pop_cnt < target) begin
      checks++; failures++;
      $display("FAIL %s_timeout got pop_cnt=%0d required >=%0d", tag, pop_cnt, target);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (src_q.size() > 0 && n < 20000) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (src_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got src=%0d exp=%0d required 0 0", tag, src_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.sl_rd, bus.sl_oe, bus.ts_valid, bus.ts_sop, bus.ts_eop, bus.ts_data, bus.ts_lock}
        !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got rd=%b oe=%b v=%b sop=%b eop=%b d=%02h lock=%b required 1 1 0 0 0 00 0",
               bus.sl_rd, bus.sl_oe, bus.ts_valid, bus.ts_sop, bus.ts_eop, bus.ts_data, bus.ts_lock);
    end
    checks++;
    if ({bus.pkt_cnt, bus.sync_err_cnt} !== 24'h0) begin
      failures++;
      $display("FAIL reset_counters got pkt=%0d err=%0d required 0 0", bus.pkt_cnt, bus.sync_err_cnt);
    end
    checks++;
    if (bus.sl_fifo_adr !== 2'b10) begin
      failures++;
      $display("FAIL fifo_adr_in_reset got %b required 10", bus.sl_fifo_adr);
    end
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.sl_oe !== 1'b0 || bus.sl_rd !== 1'b1) begin
      failures++;
      $display("FAIL oe_after_reset got oe=%b rd=%b required 0 1", bus.sl_oe, bus.sl_rd);
    end
  endtask

  task automatic test_clean();
    int sop0, eop0;
    apply_reset();
    sop0 = n_sop; eop0 = n_eop;
    push_pkt(8'h47, 1'b0);
    push_pkt(8'h47, 1'b1);
    push_pkt(8'h47, 1'b1);
    wait_pop(100, "clean_mid_p1");
    checks++;
    if (bus.ts_lock !== 1'b0) begin
      failures++;
      $display("FAIL clean_lock_p1 got %b required 0", bus.ts_lock);
    end
    drain("clean");
    checks++;
    if (bus.pkt_cnt !== 16'd2 || n_sop - sop0 != 2 || n_eop - eop0 != 2) begin
      failures++;
      $display("FAIL clean_counts got pkt=%0d sop=%0d eop=%0d required 2 2 2",
               bus.pkt_cnt, n_sop - sop0, n_eop - eop0);
    end
    checks++;
    if (bus.ts_data !== 8'h3A || bus.ts_lock !== 1'b1) begin
      failures++;
      $display("FAIL clean_hold got data=%02h lock=%b required 3a 1", bus.ts_data, bus.ts_lock);
    end
  endtask

  task automatic test_junk();
    int sop0;
    apply_reset();
    sop0 = n_sop;
    foreach (src_q[i]) ;
    src_q.push_back(8'h00); src_q.push_back(8'h11); src_q.push_back(8'h22);
    src_q.push_back(8'h33); src_q.push_back(8'h55);
    push_pkt(8'h47, 1'b0);
    push_pkt(8'h47, 1'b1);
    push_pkt(8'h47, 1'b1);
    drain("junk");
    checks++;
    if (bus.pkt_cnt !== 16'd2 || n_sop - sop0 != 2 || bus.sync_err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL junk_counts got pkt=%0d sop=%0d err=%0d required 2 2 0",
               bus.pkt_cnt, n_sop - sop0, bus.sync_err_cnt);
    end
  endtask

  task automatic test_corrupt();
    apply_reset();
    push_pkt(8'h47, 1'b0);
    push_pkt(8'h47, 1'b1);
    push_pkt(8'h00, 1'b0);
    push_pkt(8'h47, 1'b0);
    push_pkt(8'h47, 1'b1);
    wait_pop(pop_cnt + 2 * PKT_LEN + 3, "corrupt_p3");
    checks++;
    if (bus.ts_lock !== 1'b0 || bus.sync_err_cnt !== 8'd1) begin
      failures++;
      $display("FAIL corrupt_unlock got lock=%b err=%0d required 0 1", bus.ts_lock, bus.sync_err_cnt);
    end
    drain("corrupt");
    checks++;
    if (bus.pkt_cnt !== 16'd2 || bus.sync_err_cnt !== 8'd1 || bus.ts_lock !== 1'b1) begin
      failures++;
      $display("FAIL corrupt_relock got pkt=%0d err=%0d lock=%b required 2 1 1",
               bus.pkt_cnt, bus.sync_err_cnt, bus.ts_lock);
    end
  endtask

  task automatic test_empty_gap();
    int bad = 0;
    int n = 0;
    int eop0;
    apply_reset();
    eop0 = n_eop;
    push_pkt(8'h47, 1'b0);
    push_pkt(8'h47, 1'b1);
    push_pkt(8'h47, 1'b1);
    wait_pop(pop_cnt + PKT_LEN + 60, "ef_mid_p2");
    while (bus.sl_rd !== 1'b0 && n < 4 * RD_GAP) begin @(negedge clk); n++; end
    #1 ef_hold = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k >= 2 && (bus.sl_rd !== 1'b1 || bus.ts_valid !== 1'b0)) bad++;
    end
    #1 ef_hold = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL ef_quiet got %0d active cycles required 0", bad);
    end
    drain("ef");
    checks++;
    if (bus.pkt_cnt !== 16'd2 || n_eop - eop0 != 2) begin
      failures++;
      $display("FAIL ef_counts got pkt=%0d eop=%0d required 2 2", bus.pkt_cnt, n_eop - eop0);
    end
  endtask

  task automatic test_afull();
    int bad = 0;
    int n = 0;
    apply_reset();
    push_pkt(8'h47, 1'b0);
    push_pkt(8'h47, 1'b1);
    push_pkt(8'h47, 1'b1);
    wait_pop(pop_cnt + PKT_LEN + 90, "afull_mid_p2");
    while (bus.sl_rd !== 1'b0 && n < 4 * RD_GAP) begin @(negedge clk); n++; end
    #1 bus.ts_afull = 1'b1;
    for (int k = 1; k <= 3 * RD_GAP; k++) begin
      @(negedge clk);
      if (bus.sl_rd !== 1'b1) bad++;
    end
    #1 bus.ts_afull = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL afull_block got %0d read cycles required 0", bad);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (bus.sl_rd !== 1'b0 && n < 4 * RD_GAP);
    checks++;
    if (n != RD_GAP) begin
      failures++;
      $display("FAIL afull_resume got first read after %0d cycles required %0d", n, RD_GAP);
    end
    drain("afull");
    checks++;
    if (bus.pkt_cnt !== 16'd2) begin
      failures++;
      $display("FAIL afull_pkt_cnt got %0d required 2", bus.pkt_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int out0, eop0, sop0;
    apply_reset();
    push_pkt(8'h47, 1'b0);
    push_pkt(8'h47, 1'b1);
    push_pkt(8'h47, 1'b1);
    out0 = n_out; eop0 = n_eop;
    while (n_out - out0 < 100 && n < 20000) begin @(negedge clk); n++; end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.sl_rd, bus.sl_oe, bus.ts_valid, bus.ts_sop, bus.ts_eop, bus.ts_data, bus.ts_lock, bus.pkt_cnt, bus.sync_err_cnt}
        !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 8'h0}) begin
      failures++;
      $display("FAIL midreset_outputs got rd=%b oe=%b v=%b sop=%b eop=%b d=%02h lock=%b pkt=%0d err=%0d required 1 1 0 0 0 00 0 0 0",
               bus.sl_rd, bus.sl_oe, bus.ts_valid, bus.ts_sop, bus.ts_eop, bus.ts_data,
               bus.ts_lock, bus.pkt_cnt, bus.sync_err_cnt);
    end
    checks++;
    if (n_out - out0 != 100 || n_eop != eop0) begin
      failures++;
      $display("FAIL midreset_partial got out=%0d eop=%0d required 100 0", n_out - out0, n_eop - eop0);
    end
    src_q.delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    sop0 = n_sop;
    push_pkt(8'h47, 1'b0);
    push_pkt(8'h47, 1'b1);
    wait_pop(pop_cnt + 50, "midreset_hunt");
    checks++;
    if (bus.ts_lock !== 1'b0 || bus.pkt_cnt !== 16'd0) begin
      failures++;
      $display("FAIL midreset_hunt got lock=%b pkt=%0d required 0 0", bus.ts_lock, bus.pkt_cnt);
    end
    drain("midreset");
    checks++;
    if (bus.pkt_cnt !== 16'd1 || n_sop - sop0 != 1) begin
      failures++;
      $display("FAIL midreset_relock got pkt=%0d sop=%0d required 1 1", bus.pkt_cnt, n_sop - sop0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.ts_afull = 1'b0;
    test_reset();
    test_clean();
    test_junk();
    test_corrupt();
    test_empty_gap();
    test_afull();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/slfifo_ts_rx.md
# slfifo_ts_rx

Receive-side companion to the slave-FIFO transmit path. Pulls bytes from the USB controller's OUT endpoint through the slave-FIFO interface (SLOE/SLRD/empty flag). Recovers 188-byte TS packet alignment on sync byte 0x47 and presents packets downstream as a byte stream with sop/eop framing. Sits between the slave-FIFO pins and the TS demux/processing chain, in the same clk domain as the slave-FIFO interface clock.

## Interface
- PKT_LEN, 188, TS packet length in bytes
- SYNC_BYTE, 8'h47, packet start marker
- FIFO_ADR, 2'b10, slave-FIFO endpoint address driven on sl_fifo_adr
- RD_GAP, 8, clk cycles per read slot; legal range 4..255
- clk  in  1  system clock, also the slave-FIFO interface clock
- rst  in  1  reset, asynchronous, active-high
- sl_data  in  8  slave-FIFO data bus
- sl_ef  in  1  endpoint empty flag; 0: empty, 1: not empty
- sl_rd  out  1  SLRD strobe, active low
- sl_oe  out  1  SLOE output enable, active low
- sl_fifo_adr  out  2  endpoint select, constant FIFO_ADR
- ts_afull  in  1  downstream almost full; 1 blocks new reads
- ts_valid  out  1  output byte valid
- ts_data  out  8  output byte
- ts_sop  out  1  first byte of packet, qualified by ts_valid
- ts_eop  out  1  last byte of packet, qualified by ts_valid
- ts_lock  out  1  1 while packet alignment is held
- pkt_cnt  out  16  packets emitted, wraps at 16'hFFFF -> 0
- sync_err_cnt  out  8  lock losses, saturates at 8'hFF

## Operation
- Reset values: sl_rd=1, sl_oe=1, ts_valid/ts_sop/ts_eop=0, ts_data=0, ts_lock=0, pkt_cnt=0, sync_err_cnt=0; FSM in ST_HUNT; byte counter 0; gap counter 0.
- After reset release: sl_oe driven 0 from the first edge and held there. sl_fifo_adr is always FIFO_ADR, including during reset.
- sl_ef is double-registered (ef_s2).
- Gap counter runs 0..RD_GAP-1 and wraps.
- A read fires when gap==RD_GAP-1, ef_s2==1 and ts_afull==0. It does three things:
  - loads sl_data into byte_r
  - sets byte_vld for one cycle
  - drives sl_rd=0 for exactly one cycle
- No read fires in a slot whose conditions fail; the next chance is the following slot.
- FSM, one-hot, evaluated on byte_vld:
  - ST_HUNT: byte==SYNC_BYTE -> ST_VERIFY with cnt=1. Any other byte is dropped. Nothing is output.
  - ST_VERIFY: bytes are dropped and cnt increments. At cnt==PKT_LEN: byte==SYNC_BYTE -> ST_LOCK, this byte is output with ts_sop=1, cnt=1. Any other byte -> ST_HUNT.
  - ST_LOCK: every byte is output.
    - cnt==0 and byte!=SYNC_BYTE: byte dropped, -> ST_HUNT, sync_err_cnt++ (saturating).
    - cnt==0 and byte==SYNC_BYTE: ts_sop=1.
    - cnt==PKT_LEN-1: ts_eop=1, pkt_cnt++, cnt wraps to 0.
- ts_lock=1 exactly while in ST_LOCK.
- Emitted packets are always complete. Loss of lock is detected only at a packet boundary, so no partial packet is ever output.
- ts_afull is sampled only at read slots. Downstream must assert it with at least 2 bytes of headroom remaining.

## Timing
- Edge E is the read decision: byte_r is loaded and sl_rd goes low after E. sl_rd returns high after E+1.
- ts_valid/ts_data/ts_sop/ts_eop are registered at E+1, giving 1 cycle latency from the sl_rd falling edge.
- ts_valid is a one-cycle pulse, at most one per RD_GAP cycles.
- ts_data holds its value between pulses.
- The empty-flag path is 2 sync cycles plus the controller's flag update. RD_GAP>=4 guarantees no read is issued on a stale not-empty flag.
- Reset mid-packet: all state clears asynchronously. The packet in flight is abandoned with no eop, and hunting restarts.
- Simultaneous ts_afull=1 and ef_s2=1 at a slot: no read.

## Structure
- Package slfifo_pkg holds:
  - PKT_LEN and SYNC_BYTE defaults
  - state width and encodings: ST_HUNT=3'b001, ST_VERIFY=3'b010, ST_LOCK=3'b100
- Sub-module slfifo_rd_ctrl contains:
  - sl_ef synchronizer and gap counter
  - sl_rd/sl_oe generation
  - byte_r/byte_vld capture
- The top level holds the sync FSM, byte counter and statistics counters.

## Test plan
- Clean stream of 3 packets (0x47, 187 bytes of incrementing data, repeated), sl_ef=1 -> packet 1 dropped, packets 2 and 3 output; pkt_cnt=2; ts_sop and ts_eop each fire twice; ts_lock=1 from packet 2's first byte.
- 5 junk bytes, then aligned packets -> 0 bytes output until a verified 0x47; no sop before the second sync.
- While locked, corrupt one start byte to 0x00 -> that byte and the rest of its packet are not output; sync_err_cnt=1; ts_lock=0; relock 188 bytes after the next 0x47.
- sl_ef=0 for 50 cycles mid-packet -> sl_rd stays 1 and ts_valid stays 0; the stream resumes with byte count continuous and no spurious sop/eop.
- ts_afull=1 for 3 slots -> no sl_rd pulses during those slots; reads resume at the first slot after release.
- Assert rst mid-packet (byte 100) -> all outputs return to reset values immediately; ST_HUNT after release; pkt_cnt=0.
